// File: rtl/time_display_pkg.sv
// Shared constants for the multiplexed seven-segment time display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package time_display_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    // Decimal points after the hour, minute and second ones digits.
    localparam logic [NUM_DIGITS-1:0] DP_MASK = 8'b0101_0100;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

    typedef enum logic [1:0] {
        FieldHundredth = 2'd0,
        FieldSecond    = 2'd1,
        FieldMinute    = 2'd2,
        FieldHour      = 2'd3
    } field_e;

endpackage

// File: rtl/seg7_encode.sv
// Digit code (0..9, dash, blank) to active-low seven-segment pattern.
module seg7_encode
    import time_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (code <= 4'd9) begin
            seg = SEG_DIGIT[code];
        end else if (code == CODE_DASH) begin
            seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/time_display_mux.sv
// Scans HH.MM.SS.CC onto an 8-digit common-anode display, capturing all
// fields once per frame and blinking the whole display while done_signal is high.
module time_display_mux
    import time_display_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 15625,
    parameter int unsigned GUARD_TICKS = 16,
    parameter int unsigned BLINK_TICKS = 62_500_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            hour,
    input  logic [6:0]            minute,
    input  logic [6:0]            second,
    input  logic [6:0]            hundredth,
    input  logic                  done_signal,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned TickW  = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TickW-1:0]  TickLast  = TickW'(DIGIT_TICKS - 1);
    localparam logic [TickW-1:0]  TickGuard = TickW'(GUARD_TICKS);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

    logic [TickW-1:0]      tick_q, tick_d;
    logic [2:0]            idx_q, idx_d;
    logic [BlinkW-1:0]     blink_cnt_q, blink_cnt_d;
    logic                  blink_on_q, blink_on_d;
    logic                  done_q;
    logic [6:0]            hour_q, minute_q, second_q, hundredth_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  slot_end, frame_start;
    logic [6:0]            field;
    logic [3:0]            tens, ones, code;

    // Slot and digit counters; idx counts down so the frame starts at the left.
    always_comb begin
        slot_end    = (tick_q == TickLast);
        frame_start = slot_end && (idx_q == 3'd0);
        tick_d      = slot_end ? '0 : tick_q + TickW'(1);
        idx_d       = slot_end ? idx_q - 3'd1 : idx_q;
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (!done_signal || !done_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
        end
    end

    always_comb begin
        case (field_e'(idx_q[2:1]))
            FieldHour:   field = hour_q;
            FieldMinute: field = minute_q;
            FieldSecond: field = second_q;
            default:     field = hundredth_q;
        endcase
        // x*103 >> 10 equals x/10 for every x in 0..99.
        tens = 4'((14'(field) * 14'd103) >> 10);
        ones = field[3:0] - 4'(tens * 4'd10);
        if (field > 7'd99) begin
            code = CODE_DASH;
        end else if (idx_q[0]) begin
            code = ((idx_q == 3'd7) && (tens == 4'd0)) ? CODE_BLANK : tens;
        end else begin
            code = ones;
        end
    end

    seg7_encode u_seg7_encode (
        .code (code),
        .seg  (seg_d)
    );

    always_comb begin
        an_d = '1;
        if (blink_on_q && (tick_q >= TickGuard)) begin
            an_d = ~(NUM_DIGITS'(1) << idx_q);
        end
        dp_d = ~DP_MASK[idx_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q      <= '0;
            idx_q       <= 3'd7;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            done_q      <= 1'b0;
            hour_q      <= '0;
            minute_q    <= '0;
            second_q    <= '0;
            hundredth_q <= '0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            done_q      <= done_signal;
            if (frame_start) begin
                hour_q      <= hour;
                minute_q    <= minute;
                second_q    <= second;
                hundredth_q <= hundredth;
            end
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: doc/time_display_mux.md
# time_display_mux

Multiplexed 8-digit seven-segment driver for the countdown timer's time fields. It consumes `hour`, `minute`, `second`, `hundredth` and `done_signal` from the countdown timer and scans them onto a common-anode display as HH.MM.SS.CC. All four fields are captured once per scan frame so a digit never shows a mix of old and new values. The display blinks while `done_signal` is high.

## Interface
- `DIGIT_TICKS`, 15625: clock cycles per digit slot (1 kHz frame at 125 MHz).
- `GUARD_TICKS`, 16: cycles at the start of each slot with all anodes off (anti-ghosting); must be < `DIGIT_TICKS`.
- `BLINK_TICKS`, 62_500_000: cycles per blink half-period (0.5 s at 125 MHz).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `hour`, `minute`, `second`, `hundredth`  in  7 each  binary field values from the timer; valid range 0..99.
- `done_signal`  in  1  timer expired; enables blinking.
- `an`  out  8  anode enables, active-low; bit i drives digit i, where digit 0 is the rightmost.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Digit map:**
  - 0/1 = hundredth ones/tens
  - 2/3 = second ones/tens
  - 4/5 = minute ones/tens
  - 6/7 = hour ones/tens
- **Decimal points:** `dp` is lit on digits 2, 4 and 6.
- **Slot counter** `tick`: runs 0..`DIGIT_TICKS`-1. On the terminal count, `tick` returns to 0 and digit index `idx` advances 7→6→…→0→7.
- **Field capture:** all four fields are captured into shadow registers on the cycle `idx` wraps from 0 to 7, i.e. the frame start.
- **Per-digit decode:** each field is split into tens/ones (0..99).
  - A field value > 99 shows as dash (segment g only) on both of its digits.
  - Hour tens is blanked when its value is 0.
- **Blink:**
  - `blink_cnt` toggles `blink_on` every `BLINK_TICKS` cycles while `done_signal` is 1.
  - On a rising edge of `done_signal`, the counter clears and `blink_on` is set to 1.
  - While `done_signal`=0, `blink_on` is held at 1.
  - When `blink_on`=0, `an` = 8'hFF.
- **Guard window:** while `tick` < `GUARD_TICKS`, `an` = 8'hFF. Outside the guard window and with `blink_on`=1, `an` has only bit `idx` low.

## Timing
- **Reset values:**
  - `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1
  - `idx` = 7, `tick` = 0, `blink_on` = 1
  - shadow registers = 0
- **Output registering:** `an`, `seg` and `dp` are registered. Each reflects `idx`, `tick` and the shadow registers from the previous cycle (1-cycle latency).
- **First capture:** the first capture occurs at the first frame start after reset. Until then the shadow registers hold 0, so the display reads " 0.00.00.00".
- **Field-change latency:** an input field change appears on the display no later than 8·`DIGIT_TICKS` + 1 cycles after it occurs.
- **Simultaneous events:** if a frame start and a `done_signal` rise occur in the same cycle, both take effect: the capture happens and the blink phase is forced on.
- **Mid-operation reset:** asserting `reset_n` low forces all outputs to their reset values immediately (asynchronously). Release is synchronous to `clk`; counting resumes on the first rising edge after release.
- **Width rules:**
  - `tick` width = clog2(`DIGIT_TICKS`).
  - `blink_cnt` width = clog2(`BLINK_TICKS`).
  - Neither counter may overflow past its terminal count.

## Structure
- **Package `time_display_pkg`:**
  - segment constants `SEG_DIGIT[0:9]`, `SEG_DASH`, `SEG_BLANK`
  - `NUM_DIGITS` = 8
  - dp mask 8'b0101_0100
- **Sub-module `seg7_encode`:** combinational; 4-bit digit code (0..9, plus dash and blank codes) to 7-bit active-low segments.
- **Inline logic:** the tens/ones split (divide-by-10 for values ≤ 99) is inline combinational logic in the top module.

## Test plan
All scenarios use `DIGIT_TICKS`=8, `GUARD_TICKS`=2, `BLINK_TICKS`=40.
- **Reset state:** hold `reset_n`=0 → `an`=8'hFF, `seg`=7'h7F, `dp`=1. Release → `an` stays 8'hFF for 3 cycles, then `an`=8'h7F with `seg`=`SEG_BLANK` (hour tens zero).
- **Full decode:** set `hour`=12, `minute`=34, `second`=56, `hundredth`=78 before a frame start. Over the next frame, digits 7..0 show 1,2,3,4,5,6,7,8 and `dp` is low on digits 6, 4 and 2 only.
- **Capture timing:** change `second` from 56 to 55 mid-frame → the current frame still shows 56; the next frame shows 55.
- **Out-of-range field:** set `minute`=100 → digits 5 and 4 show `SEG_DASH`; all other digits are unaffected.
- **Blink:** raise `done_signal` → the display is on for 40 cycles, `an`=8'hFF for 40 cycles, and the pattern repeats. Drop `done_signal` → the display is continuously on from the next cycle.
- **Mid-scan reset:** pulse `reset_n` low mid-scan for 1 cycle → outputs take their reset values within the same cycle, and scanning restarts from digit 7.
